// File: rtl/arbiter_puf_ctrl.sv
// arbiter_puf_ctrl: sequenced, majority-voted multi-chain arbiter PUF evaluation controller
module arbiter_puf_ctrl #(
  parameter int STAGES = 64,
  parameter int CHAINS = 4,
  parameter int VOTES  = 7,
  parameter int SETTLE = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       CH_VALID,
  output logic                       CH_READY,
  input  logic [STAGES-1:0]          CH,
  output logic [STAGES-1:0]          CHAL,
  output logic                       LAUNCH,
  input  logic [CHAINS-1:0]          ARB,
  output logic                       RSP_VALID,
  input  logic                       RSP_READY,
  output logic                       RSP,
  output logic [$clog2(VOTES+1)-1:0] RSP_ONES,
  output logic                       RSP_STABLE,
  output logic                       BUSY
);
  localparam int PW = $clog2(SETTLE + 1);
  localparam int VW = $clog2(VOTES + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(SETTLE - 1);
  localparam logic [VW-1:0] V_ALL = VW'(VOTES);
  localparam logic [VW-1:0] V_HALF = VW'(VOTES / 2);
  typedef enum logic [2:0] {IDLE, LOW, HIGH, SAMPLE, DONE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [VW-1:0] vote_q, vote_d, ones_q, ones_d, rsp_ones_q, rsp_ones_d;
  logic [STAGES-1:0] chal_q, chal_d;
  logic [CHAINS-1:0] arb_m_q, arb_s_q;
  logic rsp_q, rsp_d, rsp_stable_q, rsp_stable_d;
  logic ch_ready_q, launch_q, rsp_valid_q, busy_q, vote_bit;
  assign vote_bit = ^arb_s_q;
  assign CH_READY = ch_ready_q;
  assign CHAL = chal_q;
  assign LAUNCH = launch_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP = rsp_q;
  assign RSP_ONES = rsp_ones_q;
  assign RSP_STABLE = rsp_stable_q;
  assign BUSY = busy_q;
  // two-flop synchroniser bringing the asynchronous arbiter outputs into CLK
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      arb_m_q <= '0;
      arb_s_q <= '0;
    end else begin
      arb_m_q <= ARB;
      arb_s_q <= arb_m_q;
    end
  // next-state: capture, low/high launch phases, vote accumulation, response latch on DONE entry
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    vote_d = vote_q;
    ones_d = ones_q;
    chal_d = chal_q;
    rsp_d = rsp_q;
    rsp_ones_d = rsp_ones_q;
    rsp_stable_d = rsp_stable_q;
    case (state_q)
      IDLE:
        if (CH_VALID && ch_ready_q) begin
          chal_d = CH;
          vote_d = '0;
          ones_d = '0;
          phase_d = '0;
          state_d = LOW;
        end
      LOW: begin
        phase_d = phase_q == PH_LAST ? '0 : phase_q + 1'b1;
        state_d = phase_q == PH_LAST ? HIGH : LOW;
      end
      HIGH: begin
        phase_d = phase_q == PH_LAST ? '0 : phase_q + 1'b1;
        state_d = phase_q == PH_LAST ? SAMPLE : HIGH;
      end
      SAMPLE: begin
        ones_d = ones_q + VW'(vote_bit);
        vote_d = vote_q + 1'b1;
        state_d = vote_d == V_ALL ? DONE : LOW;
        if (vote_d == V_ALL) begin
          rsp_d = ones_d > V_HALF;
          rsp_ones_d = ones_d;
          rsp_stable_d = ones_d == '0 || ones_d == V_ALL;
        end
      end
      DONE: state_d = RSP_READY ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs; handshake/launch/valid flags follow the next state
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= IDLE;
      phase_q <= '0;
      vote_q <= '0;
      ones_q <= '0;
      chal_q <= '0;
      rsp_q <= 1'b0;
      rsp_ones_q <= '0;
      rsp_stable_q <= 1'b0;
      ch_ready_q <= 1'b0;
      launch_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      vote_q <= vote_d;
      ones_q <= ones_d;
      chal_q <= chal_d;
      rsp_q <= rsp_d;
      rsp_ones_q <= rsp_ones_d;
      rsp_stable_q <= rsp_stable_d;
      ch_ready_q <= state_d == IDLE;
      launch_q <= state_d == HIGH || state_d == SAMPLE;
      rsp_valid_q <= state_d == DONE;
      busy_q <= state_d != IDLE;
    end
endmodule

// File: tb/tb_arbiter_puf_ctrl.sv
// tb_arbiter_puf_ctrl: table-driven and randomised checks of arbiter_puf_ctrl against a vote-count model
module tb_arbiter_puf_ctrl;
  localparam int S = 64, C = 4, V = 7, T = 8, P = 2 * T + 1;
  typedef struct {
    logic [S-1:0] ch;
    logic [V-1:0][C-1:0] pat;
    int hold;
    bit keep;
    bit e_rsp;
    int e_ones;
    bit e_stable;
  } vec_t;
  logic clk = 0;
  logic rst = 1, ch_valid = 0, rsp_ready = 0;
  logic [S-1:0] ch = '0;
  logic [C-1:0] arb = '0;
  logic ch_ready, launch, rsp_valid, rsp, rsp_stable, busy;
  logic [S-1:0] chal;
  logic [2:0] rsp_ones;
  logic s_valid = 0, s_ready, s_launch, s_rsp_valid, s_rsp, s_stable, s_busy;
  logic [15:0] s_ch = '0, s_chal;
  logic [0:0] s_arb = '0, s_ones;
  int errors = 0, checks = 0, cyc = 0, prev_hs = 0;
  bit prev_keep = 0;
  vec_t tbl [6];

  arbiter_puf_ctrl dut (
    .CLK(clk), .RST(rst), .CH_VALID(ch_valid), .CH_READY(ch_ready), .CH(ch), .CHAL(chal),
    .LAUNCH(launch), .ARB(arb), .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP(rsp),
    .RSP_ONES(rsp_ones), .RSP_STABLE(rsp_stable), .BUSY(busy)
  );

  arbiter_puf_ctrl #(.STAGES(16), .CHAINS(1), .VOTES(1), .SETTLE(3)) dut_s (
    .CLK(clk), .RST(rst), .CH_VALID(s_valid), .CH_READY(s_ready), .CH(s_ch), .CHAL(s_chal),
    .LAUNCH(s_launch), .ARB(s_arb), .RSP_VALID(s_rsp_valid), .RSP_READY(1'b1), .RSP(s_rsp),
    .RSP_ONES(s_ones), .RSP_STABLE(s_stable), .BUSY(s_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_ones(input logic [V-1:0][C-1:0] pat);
    int n = 0;
    for (int v = 0; v < V; v++) n += int'(^pat[v]);
    return n;
  endfunction

  task automatic run_txn(input vec_t t);
    int n = 0, bad = 0;
    while (ch_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ch_ready_before_hs", 64'(ch_ready), 64'd1);
    if (prev_keep) chk("b2b_period", 64'(cyc - prev_hs), 64'd121);
    prev_hs = cyc;
    prev_keep = t.keep;
    ch = t.ch;
    ch_valid = 1;
    arb = t.pat[0];
    rsp_ready = (t.hold == 0);
    for (int k = 1; k <= V * P; k++) begin
      @(negedge clk);
      if (k == 1) begin
        ch_valid = t.keep;
        ch = ~t.ch;
      end
      arb = t.pat[(k - 1) / P];
      bad += int'(launch !== ((k - 1) % P >= T) || busy !== 1'b1 || ch_ready !== 1'b0 ||
                  rsp_valid !== 1'b0 || chal !== t.ch);
    end
    chk("eval_profile", 64'(bad), 64'd0);
    @(negedge clk);
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rsp", 64'(rsp), 64'(t.e_rsp));
    chk("rsp_ones", 64'(rsp_ones), 64'(t.e_ones));
    chk("rsp_stable", 64'(rsp_stable), 64'(t.e_stable));
    bad = 0;
    for (int h = 0; h < t.hold; h++) begin
      ch_valid = h[0];
      ch = ~t.ch;
      @(negedge clk);
      bad += int'(rsp_valid !== 1'b1 || rsp !== t.e_rsp || 32'(rsp_ones) !== t.e_ones ||
                  rsp_stable !== t.e_stable || ch_ready !== 1'b0 || chal !== t.ch);
    end
    if (t.hold > 0) chk("rsp_hold", 64'(bad), 64'd0);
    ch_valid = t.keep;
    rsp_ready = 1;
    @(negedge clk);
    chk("idle_after_rsp", 64'({rsp_valid, ch_ready, busy}), 64'b010);
    chk("chal_held", 64'(chal), 64'(t.ch));
    rsp_ready = 0;
  endtask

  task automatic small_txn(input logic a, input logic [15:0] c);
    int n = 0;
    s_arb = a;
    s_ch = c;
    while (s_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    s_valid = 1;
    n = 0;
    do begin
      @(negedge clk);
      s_valid = 0;
      n++;
    end while (s_rsp_valid !== 1'b1 && n < 30);
    chk("small_latency", 64'(n), 64'd8);
    chk("small_chal", 64'(s_chal), 64'(c));
    chk("small_rsp", 64'({s_rsp, s_ones, s_stable}), 64'({a, a, 1'b1}));
    @(negedge clk);
    chk("small_pulse", 64'({s_rsp_valid, s_ready}), 64'b01);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{64'hA5A5_0000_FFFF_1234, {7{4'b0110}}, 0, 1'b0, 1'b0, 0, 1'b1};
    tbl[1] = '{64'h0123_4567_89AB_CDEF,
               {4'b0000, 4'b1101, 4'b1000, 4'b1111, 4'b0111, 4'b0011, 4'b0001},
               20, 1'b0, 1'b1, 4, 1'b0};
    tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, {7{4'b1110}}, 3, 1'b0, 1'b1, 7, 1'b1};
    tbl[3] = '{64'h0000_0000_0000_0001,
               {4'b0100, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0000},
               0, 1'b1, 1'b0, 3, 1'b0};
    tbl[4] = '{64'h8000_0000_0000_0000,
               {4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000},
               0, 1'b1, 1'b1, 4, 1'b0};
    tbl[5] = '{64'hDEAD_BEEF_CAFE_F00D, {{6{4'b1000}}, 4'b0000}, 1, 1'b0, 1'b1, 6, 1'b0};
    repeat (3) @(negedge clk);
    chk("reset_outs", 64'({ch_ready, launch, rsp_valid, rsp, rsp_stable, busy, rsp_ones}), 64'd0);
    chk("reset_chal", 64'(chal), 64'd0);
    chk("reset_small", 64'({s_ready, s_launch, s_rsp_valid, s_busy}), 64'd0);
    rst = 0;
    @(negedge clk);
    chk("ready_after_reset", 64'(ch_ready), 64'd1);
    foreach (tbl[i]) run_txn(tbl[i]);
    for (int r = 0; r < 16; r++) begin
      vec_t t;
      t.ch = {$urandom, $urandom};
      for (int v = 0; v < V; v++) t.pat[v] = C'($urandom_range(0, 15));
      t.hold = $urandom_range(0, 3);
      t.keep = 0;
      t.e_ones = model_ones(t.pat);
      t.e_rsp = t.e_ones > V / 2;
      t.e_stable = t.e_ones == 0 || t.e_ones == V;
      run_txn(t);
    end
    ch = 64'h1357_9BDF_0246_8ACE;
    ch_valid = 1;
    arb = 4'b0001;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      ch_valid = 0;
    end
    chk("launch_mid_high", 64'(launch), 64'd1);
    #1 rst = 1;
    #1;
    chk("rst_async_outs", 64'({launch, ch_ready, busy, rsp_valid, rsp, rsp_stable, rsp_ones}), 64'd0);
    chk("rst_async_chal", 64'(chal), 64'd0);
    repeat (2) @(negedge clk);
    rst = 0;
    run_txn(tbl[0]);
    small_txn(1'b1, 16'hBEEF);
    small_txn(1'b0, 16'h1234);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
